echo_delay_ctrl: RTL and testbench

Sequencing controller for the echo delay-line RAM (8192x9, two-port) in the audio processor. On each ADC sample strobe it runs one fixed access cycle against the RAM:
- read the delayed sample at the read pointer;
- hand the delayed sample to the datapath;
- write back the datapath result at read pointer + delay;
- advance the pointer.

It also owns delay configuration, overrun detection and a whole-memory flush. It replaces free-running pointer logic clocked by data_valid with fully sysclk-synchronous control.

---
 rtl/echo_delay_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_echo_delay_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/echo_delay_ctrl.sv
// Sequencer for the echo delay-line RAM. Each sample strobe runs one read, capture, write-back
// and pointer-advance pass. The block also handles overrun counting and a whole-memory flush.
module echo_delay_ctrl #(
  parameter int unsigned ADDR_W      = 13,
  parameter int unsigned DATA_W      = 9,
  parameter int unsigned SEL_W       = 9,
  parameter int unsigned DELAY_SHIFT = 4,
  parameter int unsigned RAM_RD_LAT  = 2
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              data_valid,
  input  logic [SEL_W-1:0]  delay_sel,
  input  logic              flush_req,
  input  logic [DATA_W:0]   wb_data,
  output logic [ADDR_W-1:0] ram_rdaddress,
  output logic              ram_rden,
  output logic [ADDR_W-1:0] ram_wraddress,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_q,
  output logic [DATA_W-1:0] echo_q,
  output logic              echo_valid,
  output logic              busy,
  output logic              overrun,
  output logic [7:0]        overrun_cnt
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StRead    = 3'd1;
  localparam logic [2:0] StWait    = 3'd2;
  localparam logic [2:0] StCapture = 3'd3;
  localparam logic [2:0] StWrite   = 3'd4;
  localparam logic [2:0] StAdvance = 3'd5;
  localparam logic [2:0] StFlush   = 3'd6;

  // Wide enough to hold the unsaturated shifted selector and the clamp limit.
  localparam int unsigned DW =
      ((SEL_W + DELAY_SHIFT) > ADDR_W ? (SEL_W + DELAY_SHIFT) : ADDR_W) + 1;
  localparam logic [DW-1:0] DelayMax = {{(DW - ADDR_W){1'b0}}, {ADDR_W{1'b1}}};
  localparam int unsigned LatW = $clog2(RAM_RD_LAT + 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] delay_q, delay_d;
  logic [ADDR_W-1:0] fcnt_q, fcnt_d;
  logic [LatW-1:0]   lat_q, lat_d;
  logic [DATA_W-1:0] echo_reg_q, echo_reg_d;
  logic              dv_q;
  logic              flush_pend_q, flush_pend_d;
  logic              overrun_q, overrun_d;
  logic [7:0]        ovr_cnt_q, ovr_cnt_d;
  logic              edge_det;
  logic [DW-1:0]     delay_raw, delay_sat;
  logic              unused_wb_lsb;

  assign unused_wb_lsb = wb_data[0];
  assign edge_det      = data_valid & ~dv_q;
  assign delay_raw     = DW'(delay_sel) << DELAY_SHIFT;

  // A zero delay would make the read and write addresses the same, so it is forced to 1.
  always_comb begin
    if (delay_raw == '0) begin
      delay_sat = DW'(1);
    end else if (delay_raw > DelayMax) begin
      delay_sat = DelayMax;
    end else begin
      delay_sat = delay_raw;
    end
  end

  always_comb begin
    state_d      = state_q;
    rd_ptr_d     = rd_ptr_q;
    delay_d      = delay_q;
    fcnt_d       = fcnt_q;
    lat_d        = lat_q;
    echo_reg_d   = echo_reg_q;
    flush_pend_d = flush_pend_q | flush_req;
    overrun_d    = edge_det & (state_q != StIdle);
    ovr_cnt_d    = ovr_cnt_q;
    if (overrun_d && (ovr_cnt_q != 8'hff)) begin
      ovr_cnt_d = ovr_cnt_q + 8'd1;
    end

    case (state_q)
      StIdle: begin
        if (edge_det) begin
          state_d = StRead;
          delay_d = delay_sat[ADDR_W-1:0];
        end else if (flush_pend_d) begin
          state_d = StFlush;
          fcnt_d  = '0;
        end
      end
      StRead: begin
        if (RAM_RD_LAT == 1) begin
          state_d = StCapture;
        end else begin
          state_d = StWait;
          lat_d   = LatW'(1);
        end
      end
      StWait: begin
        if (lat_q == LatW'(RAM_RD_LAT - 1)) begin
          state_d = StCapture;
        end else begin
          lat_d = lat_q + LatW'(1);
        end
      end
      StCapture: begin
        echo_reg_d = ram_q;
        state_d    = StWrite;
      end
      StWrite: state_d = StAdvance;
      StAdvance: begin
        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        if (flush_pend_d) begin
          state_d = StFlush;
          fcnt_d  = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StFlush: begin
        if (fcnt_q == '1) begin
          rd_ptr_d     = '0;
          flush_pend_d = 1'b0;
          state_d      = StIdle;
        end else begin
          fcnt_d = fcnt_q + ADDR_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q      <= StIdle;
      rd_ptr_q     <= '0;
      delay_q      <= '0;
      fcnt_q       <= '0;
      lat_q        <= '0;
      echo_reg_q   <= '0;
      dv_q         <= 1'b1;
      flush_pend_q <= 1'b0;
      overrun_q    <= 1'b0;
      ovr_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      delay_q      <= delay_d;
      fcnt_q       <= fcnt_d;
      lat_q        <= lat_d;
      echo_reg_q   <= echo_reg_d;
      dv_q         <= data_valid;
      flush_pend_q <= flush_pend_d;
      overrun_q    <= overrun_d;
      ovr_cnt_q    <= ovr_cnt_d;
    end
  end

  always_comb begin
    ram_rdaddress = rd_ptr_q;
    ram_rden      = (state_q == StRead);
    busy          = (state_q != StIdle);
    echo_valid    = (state_q == StWrite);
    ram_wren      = (state_q == StWrite) || (state_q == StFlush);
    ram_wraddress = '0;
    ram_data      = '0;
    if (state_q == StWrite) begin
      ram_wraddress = rd_ptr_q + delay_q;
      ram_data      = wb_data[DATA_W:1];
    end else if (state_q == StFlush) begin
      ram_wraddress = fcnt_q;
    end
  end

  assign echo_q      = echo_reg_q;
  assign overrun     = overrun_q;
  assign overrun_cnt = ovr_cnt_q;

endmodule

// File: tb/tb_echo_delay_ctrl.sv
// Bench for echo_delay_ctrl. It uses a behavioural RAM and a sample-level reference model that
// tracks the pointer, the memory image and the dropped strobes.
module tb_echo_delay_ctrl;

  localparam int AW = 13;
  localparam int DWD = 9;
  localparam int SW = 9;
  localparam int LAT = 2;
  localparam int DEPTH = 8192;

  logic           sysclk = 1'b0;
  logic           reset, data_valid, flush_req;
  logic [SW-1:0]  delay_sel;
  logic [DWD:0]   wb_data;
  logic [AW-1:0]  ram_rdaddress, ram_wraddress;
  logic           ram_rden, ram_wren, echo_valid, busy, overrun;
  logic [DWD-1:0] ram_data, ram_q, echo_q;
  logic [7:0]     overrun_cnt;

  echo_delay_ctrl #(
    .ADDR_W(AW), .DATA_W(DWD), .SEL_W(SW), .DELAY_SHIFT(4), .RAM_RD_LAT(LAT)
  ) dut (
    .sysclk(sysclk), .reset(reset), .data_valid(data_valid), .delay_sel(delay_sel),
    .flush_req(flush_req), .wb_data(wb_data), .ram_rdaddress(ram_rdaddress),
    .ram_rden(ram_rden), .ram_wraddress(ram_wraddress), .ram_wren(ram_wren),
    .ram_data(ram_data), .ram_q(ram_q), .echo_q(echo_q), .echo_valid(echo_valid),
    .busy(busy), .overrun(overrun), .overrun_cnt(overrun_cnt)
  );

  always #5 sysclk = ~sysclk;

  // Datapath stand-in: echo_q*2+2, so the stored word is echo_q+1.
  assign wb_data = {echo_q + 9'd1, 1'b0};

  // Two-cycle-latency RAM.
  logic [DWD-1:0] mem [DEPTH];
  logic [DWD-1:0] rd_s1 = '0, rd_s2 = '0;
  always @(posedge sysclk) begin
    if (ram_wren) mem[ram_wraddress] <= ram_data;
    if (ram_rden) rd_s1 <= mem[ram_rdaddress];
    rd_s2 <= rd_s1;
  end
  assign ram_q = rd_s2;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  // Monitor: logs every read and write-back and counts overrun pulses and flush writes.
  int rd_q[$], rdc_q[$], ev_echo[$], ev_wr[$], ev_data[$], evc_q[$];
  int mon_ov = 0, fl_cnt = 0, fl_bad = 0;
  always @(negedge sysclk) begin
    if (ram_rden) begin
      rd_q.push_back(int'(ram_rdaddress));
      rdc_q.push_back(cyc);
    end
    if (echo_valid) begin
      ev_echo.push_back(int'(echo_q));
      ev_wr.push_back(int'(ram_wraddress));
      ev_data.push_back(int'(ram_data));
      evc_q.push_back(cyc);
    end
    if (overrun) mon_ov++;
    if (ram_wren && !echo_valid) begin
      if (int'(ram_wraddress) != (fl_cnt % DEPTH) || ram_data != '0) fl_bad++;
      fl_cnt++;
    end
  end

  // Reference model
  int m_mem [DEPTH];
  int m_ptr = 0, m_last = -1000, m_drops = 0, ck = 0;
  int x_rd[$], x_echo[$], x_wr[$];
  int checks = 0, failures = 0;

  typedef struct { int sel; int exp_d; } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic model_edge(input int sel);
    int d, e, w;
    if (cyc - m_last >= LAT + 4) begin
      d = sel * 16;
      if (d == 0) d = 1;
      if (d > DEPTH - 1) d = DEPTH - 1;
      e = m_mem[m_ptr];
      w = (m_ptr + d) % DEPTH;
      x_rd.push_back(m_ptr);
      x_echo.push_back(e);
      x_wr.push_back(w);
      m_mem[w] = (e + 1) % 512;
      m_ptr = (m_ptr + 1) % DEPTH;
      m_last = cyc;
    end else begin
      m_drops++;
    end
  endtask

  task automatic model_flush();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
    m_ptr = 0;
    m_last = cyc - 100;
  endtask

  task automatic sample(input int sel, input int gap);
    data_valid = 1'b1;
    delay_sel = sel[SW-1:0];
    model_edge(sel);
    tick();
    data_valid = 1'b0;
    repeat (gap - 1) tick();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 10000) begin
      tick();
      n++;
    end
    chk(name, int'(busy), 0);
  endtask

  task automatic drain();
    repeat (12) tick();
    chk("rd_count", rd_q.size(), x_rd.size());
    chk("ev_count", ev_echo.size(), x_echo.size());
    for (int i = ck; i < x_rd.size() && i < rd_q.size() && i < ev_echo.size(); i++) begin
      chk("rd_addr", rd_q[i], x_rd[i]);
      chk("echo", ev_echo[i], x_echo[i]);
      chk("wr_addr", ev_wr[i], x_wr[i]);
      chk("wr_data", ev_data[i], (x_echo[i] + 1) % 512);
      chk("latency", evc_q[i] - rdc_q[i], LAT + 1);
    end
    ck = x_rd.size();
    chk("ov_pulses", mon_ov, m_drops);
    chk("ov_cnt", int'(overrun_cnt), (m_drops > 255) ? 255 : m_drops);
  endtask

  initial begin
    int fl0, n, p;
    tbl[0] = '{0, 1};
    tbl[1] = '{1, 16};
    tbl[2] = '{2, 32};
    tbl[3] = '{100, 1600};
    tbl[4] = '{256, 4096};
    tbl[5] = '{511, 8176};
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
    reset = 1'b1; data_valid = 1'b0; flush_req = 1'b0; delay_sel = '0;

    repeat (3) tick();
    @(negedge sysclk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rden", int'(ram_rden), 0);
    chk("rst_wren", int'(ram_wren), 0);
    chk("rst_echo_valid", int'(echo_valid), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_ov_cnt", int'(overrun_cnt), 0);
    chk("rst_echo_q", int'(echo_q), 0);
    chk("rst_rdaddr", int'(ram_rdaddress), 0);
    tick();
    reset = 1'b0;
    tick();

    // Initial flush, then 20 samples with d=16.
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    tick();
    wait_idle("flush0_timeout");
    chk("flush0_writes", fl_cnt, DEPTH);
    chk("flush0_bad", fl_bad, 0);
    model_flush();
    for (int i = 0; i < 20; i++) sample(1, 10);
    repeat (10) tick();
    if (ev_wr.size() >= 17) begin
      chk("s0_wr_addr", ev_wr[0], 16);
      chk("s16_echo", ev_echo[16], 1);
    end else begin
      chk("t1_samples", ev_wr.size(), 20);
    end
    drain();

    // Random spacing and delay selectors.
    for (int i = 0; i < 150; i++) sample($urandom_range(0, 511), $urandom_range(2, 12));
    drain();

    // Table of selectors against the expected delays.
    foreach (tbl[i]) begin
      p = m_ptr;
      sample(tbl[i].sel, 10);
      chk("tbl_rd", rd_q[rd_q.size() - 1], p);
      chk("tbl_wr", ev_wr[ev_wr.size() - 1], (p + tbl[i].exp_d) % DEPTH);
    end
    drain();

    // Edge pairs two cycles apart: one served, one dropped.
    for (int i = 0; i < 300; i++) begin
      sample(3, 2);
      sample(3, 8);
    end
    drain();
    chk("ov_saturated", int'(overrun_cnt), 255);

    // Flush requested during WAIT, plus an edge during the flush.
    repeat (10) tick();
    fl0 = fl_cnt;
    data_valid = 1'b1; delay_sel = 9'd3; model_edge(3);
    tick();
    data_valid = 1'b0;
    tick();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    repeat (100) tick();
    data_valid = 1'b1; m_drops++;
    tick();
    data_valid = 1'b0;
    wait_idle("flush1_timeout");
    chk("flush1_writes", fl_cnt - fl0, DEPTH);
    chk("flush1_bad", fl_bad, 0);
    model_flush();
    drain();

    // Walk the pointer to the top address and wrap it.
    n = 0;
    while (m_ptr != DEPTH - 1 && n < 9000) begin
      sample(1, 6);
      n++;
    end
    drain();
    n = rd_q.size();
    sample(1, 10);
    sample(1, 10);
    chk("wrap_rd_top", rd_q[n], DEPTH - 1);
    chk("wrap_wr", ev_wr[n], 15);
    chk("wrap_rd_zero", rd_q[n + 1], 0);
    drain();

    // Reset in WAIT, with data_valid held high through release.
    repeat (5) tick();
    n = rd_q.size();
    p = ev_echo.size();
    data_valid = 1'b1; delay_sel = 9'd1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge sysclk);
    chk("rw_busy", int'(busy), 0);
    chk("rw_rden", int'(ram_rden), 0);
    chk("rw_wren", int'(ram_wren), 0);
    chk("rw_rdaddr", int'(ram_rdaddress), 0);
    chk("rw_ov_cnt", int'(overrun_cnt), 0);
    repeat (6) tick();
    chk("rw_no_sample_rd", rd_q.size(), n + 1);
    chk("rw_no_sample_ev", ev_echo.size(), p);
    chk("rw_idle", int'(busy), 0);
    data_valid = 1'b0;
    tick();

    // Reset in FLUSH at fcnt=100.
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    repeat (100) tick();
    @(negedge sysclk);
    chk("rf_fcnt", int'(ram_wraddress), 100);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge sysclk);
    chk("rf_busy", int'(busy), 0);
    chk("rf_wren", int'(ram_wren), 0);
    chk("rf_rden", int'(ram_rden), 0);
    chk("rf_rdaddr", int'(ram_rdaddress), 0);
    repeat (5) tick();
    chk("rf_pend_cleared", int'(busy), 0);
    n = rd_q.size();
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    repeat (10) tick();
    chk("rf_next_rd_count", rd_q.size(), n + 1);
    if (rd_q.size() > n) chk("rf_next_rd", rd_q[n], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
